// File: rtl/ag_string_sequencer.sv
// ag_string_sequencer: multi-cycle address generator for repeated string
// instructions (MOVS / STOS / LODS, optionally REP-prefixed). Captures the
// operands on START and then issues one memory request per element over a
// valid/ready handshake. Each element gets a check cycle and at least one
// request cycle.
//
// Build option: define AG_SEQ_LIMIT_CHECK_EN to enable per-element segment
// limit checking (FAULT state / LIMIT_EXC). Without it the CHK cycle is
// kept, so timing is identical, but it always proceeds to REQ.
module ag_string_sequencer #(
  parameter int ADDR_W    = 32,
  parameter int CNT_W     = 32,
  parameter int SEG_W     = 16,
  parameter int SEG_SHIFT = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              START,
  input  logic [1:0]        MODE,
  input  logic [1:0]        SIZE,
  input  logic              DF,
  input  logic              REP,
  input  logic [CNT_W-1:0]  COUNT,
  input  logic [SEG_W-1:0]  SRC_SEG,
  input  logic [SEG_W-1:0]  DST_SEG,
  input  logic [ADDR_W-1:0] SRC_OFF,
  input  logic [ADDR_W-1:0] DST_OFF,
  input  logic [ADDR_W-1:0] SRC_LIMIT,
  input  logic [ADDR_W-1:0] DST_LIMIT,
  input  logic              REQ_RDY,
  input  logic              ABORT,
  output logic              BUSY,
  output logic              REQ_V,
  output logic              RD_EN,
  output logic              WR_EN,
  output logic [ADDR_W-1:0] RD_ADDR,
  output logic [ADDR_W-1:0] WR_ADDR,
  output logic [1:0]        REQ_SIZE,
  output logic [ADDR_W-1:0] SRC_OFF_OUT,
  output logic [ADDR_W-1:0] DST_OFF_OUT,
  output logic [CNT_W-1:0]  COUNT_OUT,
  output logic              DONE,
  output logic              LIMIT_EXC,
  output logic              MODE_ERR
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CHK   = 3'd1,
    ST_REQ   = 3'd2,
    ST_FIN   = 3'd3,
    ST_FAULT = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t            state_r;
  logic              mode_err_r;
  logic              rd_used_r;
  logic              wr_used_r;
  logic              df_r;
  logic [1:0]        size_r;
  logic [CNT_W-1:0]  count_r;
  logic [SEG_W-1:0]  src_seg_r;
  logic [SEG_W-1:0]  dst_seg_r;
  logic [ADDR_W-1:0] src_off_r;
  logic [ADDR_W-1:0] dst_off_r;
  logic [ADDR_W-1:0] rd_addr_r;
  logic [ADDR_W-1:0] wr_addr_r;

  // Element size in bytes (1, 2, 4 or 8) at address width.
  function automatic logic [ADDR_W-1:0] elem_bytes(input logic [1:0] sz);
    logic [ADDR_W-1:0] one_v;
    one_v = {{(ADDR_W-1){1'b0}}, 1'b1};
    return one_v << sz;
  endfunction

  // Linear address: (segment << SEG_SHIFT) + offset, wrapping at ADDR_W bits.
  function automatic logic [ADDR_W-1:0] lin_addr(input logic [SEG_W-1:0] seg,
                                                 input logic [ADDR_W-1:0] off);
    return ADDR_W'({{ADDR_W{1'b0}}, seg} << SEG_SHIFT) + off;
  endfunction

`ifdef AG_SEQ_LIMIT_CHECK_EN
  logic [ADDR_W-1:0] src_lim_r;
  logic [ADDR_W-1:0] dst_lim_r;

  // Fault when the last byte of the element lies beyond the limit; one extra
  // bit keeps an element straddling the top of the address space a fault.
  function automatic logic lim_fault(input logic [ADDR_W-1:0] off,
                                     input logic [ADDR_W-1:0] lim,
                                     input logic [1:0]        sz);
    logic [ADDR_W:0] last_v;
    last_v = {1'b0, off} + {1'b0, elem_bytes(sz)} - {{ADDR_W{1'b0}}, 1'b1};
    return last_v > {1'b0, lim};
  endfunction

  // Capture the limits with the rest of the operands.
  always_ff @(posedge CLK) begin
    if (RST) begin
      src_lim_r <= '0;
      dst_lim_r <= '0;
    end else if (state_r == ST_IDLE && START && MODE != 2'b11 &&
                 !(REP && COUNT == {CNT_W{1'b0}})) begin
      src_lim_r <= SRC_LIMIT;
      dst_lim_r <= DST_LIMIT;
    end
  end

  assign LIMIT_EXC = (state_r == ST_FAULT);
`else
  logic unused_limits_s;
  assign unused_limits_s = ^{SRC_LIMIT, DST_LIMIT};
  assign LIMIT_EXC       = 1'b0;
`endif

  // Sequencer FSM: operand capture, per-element check, request handshake.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r    <= ST_IDLE;
      mode_err_r <= 1'b0;
      rd_used_r  <= 1'b0;
      wr_used_r  <= 1'b0;
      df_r       <= 1'b0;
      size_r     <= 2'b00;
      count_r    <= '0;
      src_seg_r  <= '0;
      dst_seg_r  <= '0;
      src_off_r  <= '0;
      dst_off_r  <= '0;
      rd_addr_r  <= '0;
      wr_addr_r  <= '0;
    end else begin
      mode_err_r <= 1'b0;
      if (state_r != ST_IDLE && ABORT) begin
        // Flush wins over everything, including a same-cycle handshake.
        state_r <= ST_IDLE;
      end else begin
        case (state_r)
          ST_IDLE: begin
            if (START) begin
              if (MODE == 2'b11) begin
                mode_err_r <= 1'b1;
              end else if (REP && COUNT == {CNT_W{1'b0}}) begin
                state_r <= ST_FIN;
              end else begin
                rd_used_r <= (MODE != 2'b01);
                wr_used_r <= (MODE != 2'b10);
                df_r      <= DF;
                size_r    <= SIZE;
                count_r   <= REP ? COUNT : CNT_ONE;
                src_seg_r <= SRC_SEG;
                dst_seg_r <= DST_SEG;
                src_off_r <= SRC_OFF;
                dst_off_r <= DST_OFF;
                state_r   <= ST_CHK;
              end
            end
          end
          ST_CHK: begin
            // Addresses are registered here so they hold through any stall.
            rd_addr_r <= rd_used_r ? lin_addr(src_seg_r, src_off_r) : '0;
            wr_addr_r <= wr_used_r ? lin_addr(dst_seg_r, dst_off_r) : '0;
`ifdef AG_SEQ_LIMIT_CHECK_EN
            if ((rd_used_r && lim_fault(src_off_r, src_lim_r, size_r)) ||
                (wr_used_r && lim_fault(dst_off_r, dst_lim_r, size_r))) begin
              state_r <= ST_FAULT;
            end else begin
              state_r <= ST_REQ;
            end
`else
            state_r <= ST_REQ;
`endif
          end
          ST_REQ: begin
            if (REQ_RDY) begin
              if (rd_used_r) begin
                src_off_r <= df_r ? src_off_r - elem_bytes(size_r)
                                  : src_off_r + elem_bytes(size_r);
              end
              if (wr_used_r) begin
                dst_off_r <= df_r ? dst_off_r - elem_bytes(size_r)
                                  : dst_off_r + elem_bytes(size_r);
              end
              count_r <= count_r - CNT_ONE;
              state_r <= (count_r == CNT_ONE) ? ST_FIN : ST_CHK;
            end
          end
          ST_FIN:   state_r <= ST_IDLE;
          ST_FAULT: state_r <= ST_IDLE;
          default:  state_r <= ST_IDLE;
        endcase
      end
    end
  end

  assign BUSY        = (state_r != ST_IDLE);
  assign REQ_V       = (state_r == ST_REQ);
  assign RD_EN       = (state_r == ST_REQ) && rd_used_r;
  assign WR_EN       = (state_r == ST_REQ) && wr_used_r;
  assign RD_ADDR     = rd_addr_r;
  assign WR_ADDR     = wr_addr_r;
  assign REQ_SIZE    = size_r;
  assign SRC_OFF_OUT = src_off_r;
  assign DST_OFF_OUT = dst_off_r;
  assign COUNT_OUT   = count_r;
  assign DONE        = (state_r == ST_FIN);
  assign MODE_ERR    = mode_err_r;

endmodule

// File: tb/tb_ag_string_sequencer.sv
// Directed, table-driven bench for ag_string_sequencer plus hand-written
// sequences for timing, stall, abort, reset and error corner cases.
module tb_ag_string_sequencer;

  logic        CLK = 1'b0;
  logic        RST, START, DF, REP, REQ_RDY, ABORT;
  logic [1:0]  MODE, SIZE;
  logic [31:0] COUNT, SRC_OFF, DST_OFF, SRC_LIMIT, DST_LIMIT;
  logic [15:0] SRC_SEG, DST_SEG;
  logic        BUSY, REQ_V, RD_EN, WR_EN, DONE, LIMIT_EXC, MODE_ERR;
  logic [31:0] RD_ADDR, WR_ADDR, SRC_OFF_OUT, DST_OFF_OUT, COUNT_OUT;
  logic [1:0]  REQ_SIZE;

  always #5 CLK = ~CLK;

  ag_string_sequencer dut (
    .CLK(CLK), .RST(RST), .START(START), .MODE(MODE), .SIZE(SIZE), .DF(DF),
    .REP(REP), .COUNT(COUNT), .SRC_SEG(SRC_SEG), .DST_SEG(DST_SEG),
    .SRC_OFF(SRC_OFF), .DST_OFF(DST_OFF), .SRC_LIMIT(SRC_LIMIT),
    .DST_LIMIT(DST_LIMIT), .REQ_RDY(REQ_RDY), .ABORT(ABORT), .BUSY(BUSY),
    .REQ_V(REQ_V), .RD_EN(RD_EN), .WR_EN(WR_EN), .RD_ADDR(RD_ADDR),
    .WR_ADDR(WR_ADDR), .REQ_SIZE(REQ_SIZE), .SRC_OFF_OUT(SRC_OFF_OUT),
    .DST_OFF_OUT(DST_OFF_OUT), .COUNT_OUT(COUNT_OUT), .DONE(DONE),
    .LIMIT_EXC(LIMIT_EXC), .MODE_ERR(MODE_ERR)
  );

  typedef struct {
    logic [1:0]  mode, size;
    logic        df, rep;
    logic [31:0] count;
    logic [15:0] src_seg, dst_seg;
    logic [31:0] src_off, dst_off, src_lim, dst_lim;
    int          exp_reqs;
    logic [31:0] exp_rd, exp_wr, exp_src, exp_dst, exp_cnt;
    logic        exp_done, exp_fault;
  } vec_t;

  vec_t vecs[7];
  vec_t v;

  int n_checks = 0;
  int n_fail   = 0;

  int          r_reqs;
  logic [31:0] r_rd, r_wr;
  logic [1:0]  r_size;
  logic        r_done, r_fault, r_en_ok, r_merr, r_timeout;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Drive operands and pulse START; returns one cycle after the start edge.
  task automatic launch(input vec_t x);
    MODE = x.mode; SIZE = x.size; DF = x.df; REP = x.rep; COUNT = x.count;
    SRC_SEG = x.src_seg; DST_SEG = x.dst_seg; SRC_OFF = x.src_off;
    DST_OFF = x.dst_off; SRC_LIMIT = x.src_lim; DST_LIMIT = x.dst_lim;
    START = 1'b1;
    tick();
    START = 1'b0;
  endtask

  // Observe until DONE or LIMIT_EXC (bounded), then step one more cycle.
  task automatic run_to_end(input logic [1:0] mode);
    r_reqs = 0; r_rd = 32'h0; r_wr = 32'h0; r_size = 2'b00;
    r_done = 1'b0; r_fault = 1'b0; r_en_ok = 1'b1; r_merr = 1'b0; r_timeout = 1'b1;
    for (int c = 0; c < 200; c++) begin
      if (REQ_V && REQ_RDY) begin
        if (r_reqs == 0) begin
          r_rd = RD_ADDR; r_wr = WR_ADDR; r_size = REQ_SIZE;
        end
        r_reqs++;
        if (RD_EN !== (mode != 2'b01) || WR_EN !== (mode != 2'b10)) r_en_ok = 1'b0;
      end
      if (MODE_ERR) r_merr = 1'b1;
      if (DONE) r_done = 1'b1;
      if (LIMIT_EXC) r_fault = 1'b1;
      if (DONE || LIMIT_EXC) begin
        r_timeout = 1'b0;
        tick();
        break;
      end
      tick();
    end
  endtask

  initial begin
    // mode size df rep count srcseg dstseg srcoff dstoff srclim dstlim | reqs rd wr src dst cnt done fault
    vecs[0] = '{2'b00, 2'b10, 1'b0, 1'b1, 32'd3, 16'h0010, 16'h0020, 32'h100, 32'h200,
                32'hFFFFFFFF, 32'hFFFFFFFF, 3, 32'h00100100, 32'h00200200, 32'h10C, 32'h20C,
                32'd0, 1'b1, 1'b0};
    vecs[1] = '{2'b01, 2'b00, 1'b1, 1'b0, 32'd5, 16'h0000, 16'h0000, 32'h55, 32'h0,
                32'hFFFFFFFF, 32'hFFFFFFFF, 1, 32'h0, 32'h0, 32'h55, 32'hFFFFFFFF,
                32'd0, 1'b1, 1'b0};
`ifdef AG_SEQ_LIMIT_CHECK_EN
    vecs[2] = '{2'b10, 2'b01, 1'b0, 1'b1, 32'd4, 16'h0000, 16'h0000, 32'hFE, 32'h300,
                32'h101, 32'h0, 2, 32'hFE, 32'h0, 32'h102, 32'h300, 32'd2, 1'b0, 1'b1};
`else
    vecs[2] = '{2'b10, 2'b01, 1'b0, 1'b1, 32'd4, 16'h0000, 16'h0000, 32'hFE, 32'h300,
                32'h101, 32'h0, 4, 32'hFE, 32'h0, 32'h106, 32'h300, 32'd0, 1'b1, 1'b0};
`endif
    vecs[3] = '{2'b00, 2'b11, 1'b1, 1'b1, 32'd2, 16'hFFFF, 16'h0001, 32'h10, 32'h8,
                32'hFFFFFFFF, 32'hFFFFFFFF, 2, 32'hFFFF0010, 32'h00010008, 32'h0,
                32'hFFFFFFF8, 32'd0, 1'b1, 1'b0};
    vecs[4] = '{2'b10, 2'b00, 1'b0, 1'b1, 32'd1, 16'hFFFF, 16'h0000, 32'hFFFF0000, 32'h0,
                32'hFFFFFFFF, 32'hFFFFFFFF, 1, 32'hFFFE0000, 32'h0, 32'hFFFF0001, 32'h0,
                32'd0, 1'b1, 1'b0};
`ifdef AG_SEQ_LIMIT_CHECK_EN
    vecs[5] = '{2'b01, 2'b10, 1'b0, 1'b1, 32'd3, 16'h0000, 16'h0000, 32'h0, 32'hFE,
                32'h0, 32'h100, 0, 32'h0, 32'h0, 32'h0, 32'hFE, 32'd3, 1'b0, 1'b1};
    vecs[6] = '{2'b10, 2'b01, 1'b0, 1'b0, 32'd0, 16'h0000, 16'h0000, 32'hFFFFFFFF, 32'h0,
                32'hFFFFFFFF, 32'hFFFFFFFF, 0, 32'h0, 32'h0, 32'hFFFFFFFF, 32'h0,
                32'd1, 1'b0, 1'b1};
`else
    vecs[5] = '{2'b01, 2'b10, 1'b0, 1'b1, 32'd3, 16'h0000, 16'h0000, 32'h0, 32'hFE,
                32'h0, 32'h100, 3, 32'h0, 32'hFE, 32'h0, 32'h10A, 32'd0, 1'b1, 1'b0};
    vecs[6] = '{2'b10, 2'b01, 1'b0, 1'b0, 32'd0, 16'h0000, 16'h0000, 32'hFFFFFFFF, 32'h0,
                32'hFFFFFFFF, 32'hFFFFFFFF, 1, 32'hFFFFFFFF, 32'h0, 32'h00000001, 32'h0,
                32'd0, 1'b1, 1'b0};
`endif

    RST = 1'b1; START = 1'b0; MODE = 2'b00; SIZE = 2'b00; DF = 1'b0; REP = 1'b0;
    COUNT = 32'h0; SRC_SEG = 16'h0; DST_SEG = 16'h0; SRC_OFF = 32'h0; DST_OFF = 32'h0;
    SRC_LIMIT = 32'h0; DST_LIMIT = 32'h0; REQ_RDY = 1'b0; ABORT = 1'b0;
    tick(); tick();
    chk("reset_busy", BUSY, 1'b0);
    chk("reset_flags", {REQ_V, RD_EN, WR_EN, DONE, LIMIT_EXC, MODE_ERR}, 6'b0);
    chk("reset_addr", {RD_ADDR, WR_ADDR}, 64'h0);
    chk("reset_regs", {SRC_OFF_OUT, DST_OFF_OUT}, 64'h0);
    chk("reset_cnt", {COUNT_OUT, 30'h0, REQ_SIZE}, 64'h0);
    RST = 1'b0;
    tick();

    // Table-driven runs with the memory stage always ready.
    REQ_RDY = 1'b1;
    for (int i = 0; i < 7; i++) begin
      launch(vecs[i]);
      run_to_end(vecs[i].mode);
      chk($sformatf("v%0d_timeout", i), r_timeout, 1'b0);
      chk($sformatf("v%0d_reqs", i), r_reqs, vecs[i].exp_reqs);
      chk($sformatf("v%0d_rd_addr", i), r_rd, vecs[i].exp_rd);
      chk($sformatf("v%0d_wr_addr", i), r_wr, vecs[i].exp_wr);
      chk($sformatf("v%0d_req_size", i), r_size,
          (vecs[i].exp_reqs > 0) ? vecs[i].size : 2'b00);
      chk($sformatf("v%0d_enables", i), r_en_ok, 1'b1);
      chk($sformatf("v%0d_src_off", i), SRC_OFF_OUT, vecs[i].exp_src);
      chk($sformatf("v%0d_dst_off", i), DST_OFF_OUT, vecs[i].exp_dst);
      chk($sformatf("v%0d_count", i), COUNT_OUT, vecs[i].exp_cnt);
      chk($sformatf("v%0d_done", i), r_done, vecs[i].exp_done);
      chk($sformatf("v%0d_limit_exc", i), r_fault, vecs[i].exp_fault);
      chk($sformatf("v%0d_mode_err", i), r_merr, 1'b0);
      chk($sformatf("v%0d_idle", i), BUSY, 1'b0);
    end

    // Exact MOVS timing, with a START during BUSY that must be ignored.
    launch(vecs[0]);
    chk("t1_busy", BUSY, 1'b1);
    chk("t1_req_v", REQ_V, 1'b0);
    tick();
    chk("t2_req_v", REQ_V, 1'b1);
    chk("t2_rd_addr", RD_ADDR, 32'h00100100);
    START = 1'b1; MODE = 2'b11;
    tick();
    START = 1'b0; MODE = 2'b00;
    chk("t3_req_v", REQ_V, 1'b0);
    chk("t3_mode_err", MODE_ERR, 1'b0);
    tick();
    chk("t4_rd_addr", RD_ADDR, 32'h00100104);
    tick(); tick();
    chk("t6_rd_addr", RD_ADDR, 32'h00100108);
    chk("t6_done", DONE, 1'b0);
    tick();
    chk("t7_done", DONE, 1'b1);
    chk("t7_count", COUNT_OUT, 32'd0);
    chk("t7_src_off", SRC_OFF_OUT, 32'h10C);
    tick();
    chk("t8_busy", BUSY, 1'b0);
    chk("t8_done", DONE, 1'b0);

    // REP with COUNT = 0: DONE at t+1, no request.
    v = vecs[0]; v.count = 32'd0;
    launch(v);
    chk("cnt0_done", DONE, 1'b1);
    chk("cnt0_req_v", REQ_V, 1'b0);
    tick();
    chk("cnt0_done_end", DONE, 1'b0);
    chk("cnt0_idle", BUSY, 1'b0);

    // Illegal MODE: MODE_ERR at t+1, never busy.
    v = vecs[0]; v.mode = 2'b11;
    launch(v);
    chk("merr_pulse", MODE_ERR, 1'b1);
    chk("merr_busy", BUSY, 1'b0);
    tick();
    chk("merr_end", MODE_ERR, 1'b0);
    chk("merr_busy2", BUSY, 1'b0);

    // Stall for 5 cycles, then ABORT together with REQ_RDY.
    REQ_RDY = 1'b0;
    launch(vecs[0]);
    tick();
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("stall%0d_req_v", k), REQ_V, 1'b1);
      chk($sformatf("stall%0d_addr", k), {RD_ADDR, WR_ADDR}, 64'h00100100_00200200);
      chk($sformatf("stall%0d_size", k), {RD_EN, WR_EN, REQ_SIZE}, 4'b1110);
      tick();
    end
    ABORT = 1'b1; REQ_RDY = 1'b1;
    tick();
    ABORT = 1'b0;
    chk("abort_busy", BUSY, 1'b0);
    chk("abort_done", {DONE, LIMIT_EXC, REQ_V}, 3'b000);
    chk("abort_offs", {SRC_OFF_OUT, DST_OFF_OUT}, 64'h00000100_00000200);
    chk("abort_count", COUNT_OUT, 32'd3);
    tick();
    chk("abort_no_done", DONE, 1'b0);

    // Reset during REQ of element 2, then a normal run.
    launch(vecs[0]);
    tick(); tick(); tick();
    chk("rst_pre_req_v", REQ_V, 1'b1);
    chk("rst_pre_addr", RD_ADDR, 32'h00100104);
    RST = 1'b1;
    tick();
    RST = 1'b0;
    chk("rst_busy", BUSY, 1'b0);
    chk("rst_flags", {REQ_V, RD_EN, WR_EN, DONE, LIMIT_EXC, MODE_ERR}, 6'b0);
    chk("rst_addr", {RD_ADDR, WR_ADDR}, 64'h0);
    chk("rst_offs", {SRC_OFF_OUT, DST_OFF_OUT}, 64'h0);
    chk("rst_cnt", {COUNT_OUT, 30'h0, REQ_SIZE}, 64'h0);
    tick();
    launch(vecs[0]);
    run_to_end(vecs[0].mode);
    chk("rerun_timeout", r_timeout, 1'b0);
    chk("rerun_reqs", r_reqs, 3);
    chk("rerun_done", r_done, 1'b1);
    chk("rerun_src_off", SRC_OFF_OUT, 32'h10C);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ag_string_sequencer.md
# ag_string_sequencer

Multi-cycle address generation sequencer for repeated string instructions (MOVS, STOS, LODS, with or without REP). It sits beside the address generation stage. On a start pulse it captures segment, offset, count and limit operands, then issues one memory request per element to the memory stage over a valid/ready handshake. It supports per-element segment limit checking and a direction flag. It is the parametrised, stateful successor to the single-shot segment:offset adder path; linear address width, count width and segment shift are configurable.

## Interface
Parameters:
- ADDR_W, 32, width of offsets, limits and linear addresses
- CNT_W, 32, width of the element count
- SEG_W, 16, width of segment selector values
- SEG_SHIFT, 16, left shift applied to a segment value before adding the offset

Ports:
- CLK  in  1  clock; all state updates on rising edge
- RST  in  1  synchronous, active-high reset; highest priority
- START  in  1  one-cycle start pulse; sampled only in IDLE
- MODE  in  2  00 MOVS (read src, write dst), 01 STOS (write dst), 10 LODS (read src), 11 illegal
- SIZE  in  2  element size: 00 = 1 B, 01 = 2 B, 10 = 4 B, 11 = 8 B
- DF  in  1  direction flag: 0 increments, 1 decrements
- REP  in  1  1 = repeat COUNT times; 0 = exactly one element
- COUNT  in  CNT_W  element count (ECX)
- SRC_SEG, DST_SEG  in  SEG_W  source/destination segment values
- SRC_OFF, DST_OFF  in  ADDR_W  initial source/destination offsets (ESI/EDI)
- SRC_LIMIT, DST_LIMIT  in  ADDR_W  highest legal offset per segment
- REQ_RDY  in  1  memory stage accepts the current request
- ABORT  in  1  pipeline flush; cancels the sequence
- BUSY  out  1  high in any state other than IDLE
- REQ_V  out  1  request valid
- RD_EN, WR_EN  out  1  request reads source / writes destination
- RD_ADDR, WR_ADDR  out  ADDR_W  linear addresses for the current element
- REQ_SIZE  out  2  registered SIZE
- SRC_OFF_OUT, DST_OFF_OUT  out  ADDR_W  current offset registers
- COUNT_OUT  out  CNT_W  remaining element count
- DONE  out  1  one-cycle pulse on normal completion
- LIMIT_EXC  out  1  one-cycle pulse on a segment limit fault
- MODE_ERR  out  1  one-cycle pulse when START arrives with MODE = 11

## Operation
- States: IDLE, CHK, REQ, FIN, FAULT.
- IDLE + START:
  - MODE = 11: MODE_ERR pulses next cycle; state stays IDLE.
  - REP = 1 and COUNT = 0: go to FIN; no request is issued.
  - Otherwise: capture all operands; the count register loads COUNT when REP = 1, else 1; go to CHK.
- CHK checks each used side: off + bytes − 1 > limit, computed in ADDR_W+1 bits, counts as a fault.
  - Any fault: go to FAULT. Offsets and count are left unchanged, so the state is precise.
  - No fault: go to REQ.
- REQ: REQ_V = 1.
  - RD_ADDR = (SRC_SEG << SEG_SHIFT) + src_off, modulo 2^ADDR_W.
  - WR_ADDR is formed the same way from the destination segment and offset.
  - RD_EN and WR_EN follow MODE. An unused address outputs 0.
  - On REQ_V & REQ_RDY: each used offset changes by ±bytes (DF selects the sign), wrapping modulo 2^ADDR_W, and count decrements.
  - If the new count is 0, go to FIN; else go to CHK.
- FIN: DONE = 1, then go to IDLE.
- FAULT: LIMIT_EXC = 1, then go to IDLE.
- ABORT in any non-IDLE state: go to IDLE next cycle with no DONE or LIMIT_EXC pulse.
  - ABORT beats a same-cycle handshake: offsets and count are not updated.
- START while BUSY is ignored.
- Reset value of every output and register is 0; the state resets to IDLE.

## Timing
- All outputs come from registers or decode the state; there are no combinational paths from inputs to outputs.
- START at cycle t: CHK at t+1; first REQ_V at t+2.
- Per element: one CHK cycle plus at least one REQ cycle. With REQ_RDY held high, throughput is one element every 2 cycles.
- Completion: DONE appears 1 cycle after the last handshake. For REP with COUNT = 0, DONE appears at t+1.
- While REQ_V = 1 and REQ_RDY = 0, REQ_V, addresses, enables and REQ_SIZE hold stable.
- After DONE, LIMIT_EXC or ABORT, BUSY drops in the same cycle the state reaches IDLE. A new START is accepted from that cycle on.
- RST asserted mid-sequence: IDLE on the next edge with all outputs 0; no pulses are emitted.

## Configuration
- AG_SEQ_LIMIT_CHECK_EN defined: CHK performs the limit comparison, and FAULT/LIMIT_EXC are reachable.
- AG_SEQ_LIMIT_CHECK_EN undefined: the comparator is removed and CHK always proceeds to REQ. LIMIT_EXC is tied to 0. CHK is retained, so cycle timing is identical in both builds.

## Test plan
- MOVS, SIZE = 10, DF = 0, REP = 1, COUNT = 3, SRC_SEG = 0x0010, SRC_OFF = 0x100, REQ_RDY = 1 -> RD_ADDR = 0x00100100, 0x00100104, 0x00100108; DONE at t+7; COUNT_OUT = 0; SRC_OFF_OUT = 0x10C.
- STOS, SIZE = 00, DF = 1, REP = 0, DST_OFF = 0 -> one write request (RD_EN = 0, RD_ADDR = 0); DST_OFF_OUT wraps to 0xFFFFFFFF.
- LODS, SIZE = 01, REP = 1, COUNT = 4, SRC_OFF = 0xFE, SRC_LIMIT = 0x101 -> two requests issued, then LIMIT_EXC; COUNT_OUT = 2, SRC_OFF_OUT = 0x102. Without the macro, four requests and DONE.
- REP = 1, COUNT = 0 -> DONE at t+1; REQ_V never asserts. MODE = 11 -> MODE_ERR at t+1; BUSY stays 0.
- REQ_RDY held low for 5 cycles -> REQ_V and addresses stable throughout. ABORT together with REQ_RDY -> IDLE next cycle, offsets and count unchanged, no DONE.
- RST asserted during REQ of element 2 -> all outputs 0 and BUSY = 0 next cycle; a START two cycles later runs normally.
